// File: rtl/sim_control_if.sv
// Wishbone classic bus bundle for the sim_control test-control peripheral.
// Signal suffixes are named from the slave's point of view.
interface sim_control_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o, rty_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/sim_control.sv
// Simulation test-control peripheral: signature bounds + HALT register, RAM signature dump.
// Optional watchdog enabled by defining CONTROL_TIMEOUT_EN.
module sim_control #(
    parameter logic [31:0] BASE_ADDRESS        = 32'h3000_0000,
    parameter logic [31:0] MEMORY_BASE_ADDRESS = 32'h2000_0000,
    parameter logic [31:0] MEMORY_SIZE         = 32'h0000_4000,
    parameter int unsigned TIMEOUT_CYCLES      = 200000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sim_control_if.slave      wb,
    output logic              mem_rd_o,
    output logic [31:0]       mem_adr_o,
    input  logic [31:0]       mem_dat_i,
    output logic              sig_valid_o,
    output logic [31:0]       sig_data_o,
    output logic              done_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [32:0] MEM_LO = {1'b0, MEMORY_BASE_ADDRESS};
    localparam logic [32:0] MEM_HI = {1'b0, MEMORY_BASE_ADDRESS} + {1'b0, MEMORY_SIZE};

    state_t      state_q, state_d;
    logic        ack_q, err_q;
    logic [31:0] dat_q;
    logic [31:0] sig_begin, sig_end;
    logic [31:0] cur_adr, end_q;
    logic        fail_q;

    // Handshake: a request is cyc & stb with the address in our 32-byte window.
    // ack/err are registered one-cycle pulses; while either is high no new
    // request is taken, so a held strobe is answered every second cycle.
    logic        selected, req, mapped, halt_cmd, bounds_ok;
    logic [1:0]  reg_idx;
    logic [31:0] status, rd_data;

    assign selected = wb.cyc_i & wb.stb_i & (wb.adr_i[31:5] == BASE_ADDRESS[31:5]);
    assign req      = selected & ~ack_q & ~err_q;
    assign mapped   = ~wb.adr_i[4];
    assign reg_idx  = wb.adr_i[3:2];
    assign halt_cmd = req & mapped & wb.we_i & (reg_idx == 2'd2) & wb.sel_i[0] & wb.dat_i[0];

    assign status = {27'd0, timeout_o, fail_q, (state_q == S_DONE),
                     (state_q == S_CHECK) | (state_q == S_REQ) | (state_q == S_WAIT),
                     (state_q != S_IDLE)};

    always_comb begin
        rd_data = 32'd0;
        case (reg_idx)
            2'd0:    rd_data = sig_begin;
            2'd1:    rd_data = sig_end;
            2'd3:    rd_data = status;
            default: rd_data = 32'd0;
        endcase
    end

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= 32'd0;
            sig_begin <= 32'd0;
            sig_end   <= 32'd0;
        end else begin
            ack_q <= req & mapped;
            err_q <= req & ~mapped;
            dat_q <= (req & mapped & ~wb.we_i) ? rd_data : 32'd0;
            if (req & mapped & wb.we_i) begin
                if (reg_idx == 2'd0) sig_begin <= merge_bytes(sig_begin, wb.dat_i, wb.sel_i);
                if (reg_idx == 2'd1) sig_end   <= merge_bytes(sig_end, wb.dat_i, wb.sel_i);
            end
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.err_o = err_q;
    assign wb.dat_o = dat_q;
    assign wb.rty_o = 1'b0;

    // Bounds are judged on the live registers in CHECK, the same values latched there.
    assign bounds_ok = (sig_begin[1:0] == 2'b00) && (sig_end[1:0] == 2'b00) &&
                       ({1'b0, sig_begin} >= MEM_LO) && (sig_begin <= sig_end) &&
                       ({1'b0, sig_end} <= MEM_HI);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_rd_o    = 1'b0;
        mem_adr_o   = 32'd0;
        sig_valid_o = 1'b0;
        sig_data_o  = 32'd0;
        case (state_q)
            S_IDLE:  if (halt_cmd) state_d = S_CHECK;
            S_CHECK: begin
                if (!bounds_ok || (sig_begin == sig_end)) state_d = S_DONE;
                else                                      state_d = S_REQ;
            end
            S_REQ: begin
                mem_rd_o  = 1'b1;
                mem_adr_o = cur_adr - MEMORY_BASE_ADDRESS;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                sig_valid_o = 1'b1;
                sig_data_o  = mem_dat_i;
                state_d     = ((cur_adr + 32'd4) == end_q) ? S_DONE : S_REQ;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cur_adr <= 32'd0;
            end_q   <= 32'd0;
            fail_q  <= 1'b0;
        end else begin
            if (state_q == S_CHECK) begin
                cur_adr <= sig_begin;
                end_q   <= sig_end;
                if (!bounds_ok) fail_q <= 1'b1;
            end
            if (state_q == S_WAIT) cur_adr <= cur_adr + 32'd4;
        end
    end

    assign done_o      = (state_q == S_DONE);
    assign fail_o      = fail_q;
    assign dbg_state_o = state_q;

`ifdef CONTROL_TIMEOUT_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);
    logic [31:0] wd_cnt;

    // Counts idle cycles only and freezes at the limit, keeping timeout_o sticky.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                                           wd_cnt <= 32'd0;
        else if ((state_q == S_IDLE) && (wd_cnt != WD_LIMIT)) wd_cnt <= wd_cnt + 32'd1;
    end

    assign timeout_o = (wd_cnt == WD_LIMIT);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_o      = 1'b0;
`endif

    logic unused_adr;
    assign unused_adr = ^wb.adr_i[1:0];

endmodule

// File: tb/tb_sim_control.sv
// Self-checking bench for sim_control: register vector table, signature dumps
// against a RAM model with an expected-word scoreboard, reset and watchdog sequences.
module tb_sim_control;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] MBASE = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sim_control_if bus();
    logic        mem_rd, sig_valid, done, fail, timeout;
    logic [31:0] mem_adr, mem_dat, sig_data;
    logic [2:0]  dbg_state;

    sim_control #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i(clk), .rst_i(rst_n), .wb(bus.slave),
        .mem_rd_o(mem_rd), .mem_adr_o(mem_adr), .mem_dat_i(mem_dat),
        .sig_valid_o(sig_valid), .sig_data_o(sig_data),
        .done_o(done), .fail_o(fail), .timeout_o(timeout), .dbg_state_o(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM model: data valid the cycle after a read request
    logic [31:0] ram [0:4095];
    always @(posedge clk) mem_dat <= mem_rd ? ram[mem_adr[13:2]] : 32'h0;

    // Scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] exp_adr_q[$];
    int sig_cnt = 0;
    int rd_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                rd_cnt++;
                if (exp_adr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_rd unexpected: adr 0x%08h, none expected", mem_adr);
                end else check("mem_adr", mem_adr, exp_adr_q.pop_front());
            end
            if (sig_valid) begin
                sig_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sig_valid unexpected: data 0x%08h, none expected", sig_data);
                end else check("sig_data", sig_data, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic bus_idle();
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.adr_i = 32'h0; bus.sel_i = 4'h0; bus.dat_i = 32'h0;
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, output logic ack, output logic err,
                             output logic [31:0] rdat, output int lat);
        @(posedge clk); #1;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = adr; bus.sel_i = sel; bus.dat_i = dat;
        ack = 1'b0; err = 1'b0; rdat = 32'h0; lat = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            rdat = bus.dat_o;
            if (bus.ack_o || bus.err_o) begin
                ack = bus.ack_o; err = bus.err_o; lat = c;
                break;
            end
        end
        bus_idle();
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        logic a, e; logic [31:0] d; int lat;
        wb_access(1'b1, adr, sel, dat, a, e, d, lat);
        check("write ack", {31'd0, a}, 32'd1);
        check("write latency", lat, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        logic a, e; int lat;
        wb_access(1'b0, adr, 4'hF, 32'h0, a, e, d, lat);
        check("read ack", {31'd0, a}, 32'd1);
    endtask

    task automatic do_reset();
        bus_idle();
        rst_n = 1'b0;
        #1;
        check("reset ctl outputs",
              {24'd0, bus.ack_o, bus.err_o, bus.rty_o, done, fail, timeout, mem_rd, sig_valid}, 32'd0);
        check("reset dat_o", bus.dat_o, 32'd0);
        check("reset mem_adr", mem_adr, 32'd0);
        check("reset sig_data", sig_data, 32'd0);
        check("reset state", {29'd0, dbg_state}, 32'd0);
        exp_q.delete();
        exp_adr_q.delete();
        sig_cnt = 0;
        rd_cnt = 0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_dump(input logic [31:0] b, input logic [31:0] e,
                            input logic exp_fail, input int exp_words);
        logic [31:0] st;
        int rd0, sig0;
        wb_write(BASE + 32'h0, 4'hF, b);
        wb_write(BASE + 32'h4, 4'hF, e);
        if (!exp_fail) begin
            for (logic [31:0] a = b; a < e; a += 4) begin
                exp_adr_q.push_back(a - MBASE);
                exp_q.push_back(ram[(a - MBASE) >> 2]);
            end
        end
        rd0 = rd_cnt; sig0 = sig_cnt;
        wb_write(BASE + 32'h8, 4'hF, 32'h1);
        for (int c = 0; c < 2 * exp_words + 20; c++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check("dump done", {31'd0, done}, 32'd1);
        check("dump fail", {31'd0, fail}, {31'd0, exp_fail});
        check("dump words", sig_cnt - sig0, exp_words);
        check("dump ram reads", rd_cnt - rd0, exp_words);
        check("dump words left", exp_q.size(), 32'd0);
        wb_read(BASE + 32'hC, st);
        check("dump status", st & 32'hFFFF_FFEF, exp_fail ? 32'hD : 32'h5);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic a, e; logic [31:0] d; int lat;
        logic [3:0] pattern;
        logic [31:0] rb, b, eaddr;
        int k, n;

        vecs[0]  = '{"rd sig_begin rst", 0, BASE + 32'h00, 4'hF, 32'h0, 1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[1]  = '{"rd status rst",    0, BASE + 32'h0C, 4'hF, 32'h0, 1, 0, 32'h0, 32'hFFFF_FFEF};
        vecs[2]  = '{"wr begin byte1",   1, BASE + 32'h00, 4'h2, 32'h0000_AB00, 1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[3]  = '{"rd begin byte1",   0, BASE + 32'h00, 4'hF, 32'h0, 1, 0, 32'h0000_AB00, 32'hFFFF_FFFF};
        vecs[4]  = '{"wr end full",      1, BASE + 32'h04, 4'hF, 32'h1234_5678, 1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[5]  = '{"wr end byte3",     1, BASE + 32'h04, 4'h8, 32'hAA00_0000, 1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[6]  = '{"rd end merged",    0, BASE + 32'h04, 4'hF, 32'h0, 1, 0, 32'hAA34_5678, 32'hFFFF_FFFF};
        vecs[7]  = '{"wr status",        1, BASE + 32'h0C, 4'hF, 32'hFFFF_FFFF, 1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[8]  = '{"rd status ro",     0, BASE + 32'h0C, 4'hF, 32'h0, 1, 0, 32'h0, 32'hFFFF_FFEF};
        vecs[9]  = '{"rd halt",          0, BASE + 32'h08, 4'hF, 32'h0, 1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[10] = '{"rd unmapped 14",   0, BASE + 32'h14, 4'hF, 32'h0, 0, 1, 32'h0, 32'hFFFF_FFFF};
        vecs[11] = '{"wr unmapped 10",   1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, 0, 1, 32'h0, 32'hFFFF_FFFF};
        vecs[12] = '{"rd other slave",   0, 32'h2000_0000, 4'hF, 32'h0, 0, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[13] = '{"halt no sel0",     1, BASE + 32'h08, 4'h2, 32'h0000_0001, 1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[14] = '{"status still idle",0, BASE + 32'h0C, 4'hF, 32'h0, 1, 0, 32'h0, 32'hFFFF_FFEF};

        for (int i = 0; i < 4096; i++) ram[i] = $urandom();
        ram[32'h100 >> 2] = 32'h11;
        ram[32'h104 >> 2] = 32'h22;
        ram[32'h108 >> 2] = 32'h33;
        ram[32'h10C >> 2] = 32'h44;

        // Watchdog from reset release
        do_reset();
`ifdef CONTROL_TIMEOUT_EN
        k = 0;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); #1;
            if (timeout) begin k = c; break; end
        end
        check("timeout latency", k, 32'd100);
        wb_read(BASE + 32'hC, rb);
        check("status timeout bit", rb, 32'h10);
`else
        repeat (150) @(posedge clk);
        #1;
        check("timeout disabled", {31'd0, timeout}, 32'd0);
        wb_read(BASE + 32'hC, rb);
        check("status no timeout", rb, 32'h0);
`endif

        // Register vector table
        do_reset();
        for (int i = 0; i < 15; i++) begin
            wb_access(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, a, e, d, lat);
            check({vecs[i].name, " ack"}, {31'd0, a}, {31'd0, vecs[i].exp_ack});
            check({vecs[i].name, " err"}, {31'd0, e}, {31'd0, vecs[i].exp_err});
            check({vecs[i].name, " dat"}, d & vecs[i].mask, vecs[i].exp_dat);
            if (vecs[i].exp_ack || vecs[i].exp_err)
                check({vecs[i].name, " latency"}, lat, 32'd1);
        end
        check("no dump started", {31'd0, done} | {31'd0, fail} | rd_cnt, 32'd0);

        // Held strobe: one ack every second cycle
        @(posedge clk); #1;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = BASE + 32'h4; bus.sel_i = 4'hF;
        pattern = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            pattern = {pattern[2:0], bus.ack_o};
        end
        bus_idle();
        check("held strobe acks", {28'd0, pattern}, 32'hA);

        // Nominal four-word dump, then halt/bounds writes after DONE are ignored
        do_reset();
        run_dump(32'h2000_0100, 32'h2000_0110, 1'b0, 4);
        n = rd_cnt;
        wb_write(BASE + 32'h0, 4'hF, 32'h2000_0200);
        wb_write(BASE + 32'h4, 4'hF, 32'h2000_0300);
        wb_write(BASE + 32'h8, 4'hF, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        check("halt after done ignored", rd_cnt - n, 32'd0);
        wb_read(BASE + 32'h4, rb);
        check("sig_end rw in done", rb, 32'h2000_0300);
        wb_read(BASE + 32'hC, rb);
        check("status after done", rb & 32'hFFFF_FFEF, 32'h5);

        // Empty region
        do_reset();
        run_dump(32'h2000_0200, 32'h2000_0200, 1'b0, 0);

        // Invalid bounds
        do_reset();
        run_dump(32'h2000_0100, 32'h2000_4004, 1'b1, 0);
        do_reset();
        run_dump(32'h2000_0002, 32'h2000_0010, 1'b1, 0);
        do_reset();
        run_dump(32'h1FFF_FFFC, 32'h2000_0010, 1'b1, 0);
        do_reset();
        run_dump(32'h2000_0020, 32'h2000_0010, 1'b1, 0);

        // Last word of RAM is a legal boundary
        do_reset();
        run_dump(32'h2000_3FFC, 32'h2000_4000, 1'b0, 1);

        // Random region
        do_reset();
        n = $urandom_range(2, 12);
        b = MBASE + ({20'd0, 12'($urandom_range(0, 3000))} << 2);
        eaddr = b + 32'(n * 4);
        run_dump(b, eaddr, 1'b0, n);

        // Reset in the middle of a dump
        do_reset();
        wb_write(BASE + 32'h0, 4'hF, 32'h2000_0400);
        wb_write(BASE + 32'h4, 4'hF, 32'h2000_0440);
        for (logic [31:0] x = 32'h400; x < 32'h440; x += 4) begin
            exp_adr_q.push_back(x);
            exp_q.push_back(ram[x >> 2]);
        end
        wb_write(BASE + 32'h8, 4'hF, 32'h1);
        repeat (9) @(posedge clk);
        #3;
        check("mid-dump busy", {31'd0, done}, 32'd0);
        do_reset();
        wb_read(BASE + 32'h0, rb);
        check("sig_begin after abort", rb, 32'h0);
        wb_read(BASE + 32'hC, rb);
        check("status after abort", rb & 32'hFFFF_FFEF, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
